// File: rtl/poly1305_msg_packer.sv
// poly1305_msg_packer: packs a 32-bit little-endian word stream into padded 128-bit Poly1305 blocks.
// Latency: last word accepted at edge E -> ld in cycle after E; blk_rdy at edge F -> msg_done in cycle after F.
// Backpressure: in_ready drops from block issue (SEND) until the core returns blk_rdy in WAIT.
module poly1305_msg_packer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [2:0]       in_bytes,
    input  logic             in_last,
    output logic [127:0]     m,
    output logic             fb,
    output logic             ld,
    output logic             first,
    input  logic             blk_rdy,
    output logic             msg_done,
    output logic             msg_empty,
    output logic [CNT_W-1:0] blk_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {FILL, SEND, WAIT} state_t;

    state_t             state_q, state_d;
    logic [127:0]       buf_q;         // bytes gathered so far; unwritten bytes stay zero
    logic [1:0]         wi_q;          // next word slot, byte offset = 4*wi_q
    logic               first_flag_q;  // next issued block starts a message
    logic               final_q;       // block in flight closes its message

    logic               accept;
    logic [2:0]         n;
    logic [31:0]        wdat;
    logic [4:0]         b;
    logic [127:0]       nbuf;
    logic [127:0]       blk;
    logic               form_blk;
    logic               empty_end;
    logic [CNT_W-1:0]   cnt_base;

    // Merge the incoming word into the buffer and work out what the accept edge does.
    always_comb begin
        accept = in_valid && in_ready;
        n      = in_last ? ((in_bytes > 3'd4) ? 3'd4 : in_bytes) : 3'd4;
        wdat   = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(n)) begin
                wdat[8*i +: 8] = in_data[8*i +: 8];
            end
        end
        b         = {1'b0, wi_q, 2'b00} + {2'b00, n};
        nbuf      = buf_q | ({96'b0, wdat} << {wi_q, 5'b00000});
        form_blk  = accept && ((b == 5'd16) || (in_last && (b != 5'd0)));
        empty_end = accept && in_last && (b == 5'd0);
        // A partial block gets the 0x01 pad byte right after the last data byte.
        blk = nbuf;
        if (b != 5'd16) begin
            blk = nbuf | (128'd1 << {b[3:0], 3'b000});
        end
        // The block counter restarts with the first word of a new message.
        cnt_base = first_flag_q ? '0 : blk_cnt;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: fill until a block forms, issue it, then wait for the core.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (form_blk) state_d = SEND;
            SEND:    state_d = WAIT;
            WAIT:    if (blk_rdy) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        in_ready = (state_q == FILL);
        ld       = (state_q == SEND);
        busy     = (state_q != FILL) || (wi_q != 2'd0);
    end

    // Buffer, block registers, counters and end-of-message pulses.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q        <= '0;
            wi_q         <= '0;
            first_flag_q <= 1'b1;
            final_q      <= 1'b0;
            m            <= '0;
            fb           <= 1'b0;
            first        <= 1'b0;
            blk_cnt      <= '0;
            msg_done     <= 1'b0;
            msg_empty    <= 1'b0;
        end else begin
            msg_done  <= 1'b0;
            msg_empty <= 1'b0;
            case (state_q)
                FILL: begin
                    if (accept) begin
                        blk_cnt <= cnt_base;
                        if (empty_end) begin
                            msg_done     <= 1'b1;
                            msg_empty    <= (cnt_base == '0);
                            first_flag_q <= 1'b1;
                        end else begin
                            buf_q <= nbuf;
                            wi_q  <= wi_q + 2'd1;
                        end
                        if (form_blk) begin
                            m       <= blk;
                            fb      <= (b == 5'd16);
                            first   <= first_flag_q;
                            final_q <= in_last;
                            blk_cnt <= (cnt_base == '1) ? cnt_base : cnt_base + CNT_W'(1);
                        end
                    end
                end
                WAIT: begin
                    if (blk_rdy) begin
                        buf_q        <= '0;
                        wi_q         <= '0;
                        first_flag_q <= final_q;
                        msg_done     <= final_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
